mat_result_serializer: RTL and testbench

//  Drains the parallel NxN result of mat_mul into a row-major element stream.

---
 rtl/mat_result_serializer.sv | 130 +++++++++++++
 tb/tb_mat_result_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mat_result_serializer.sv
// Streams an NxN result matrix out as row-major beats on a valid/ready port.
// Two banks ping-pong so a new matrix can be captured while the previous one drains.
module mat_result_serializer #(
  parameter int unsigned W_OUT = 32,
  parameter int unsigned N     = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          valid_in,
  input  logic [N-1:0][N-1:0][W_OUT-1:0] result_in,
  output logic signed [W_OUT-1:0]       m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          full,
  output logic                          overflow,
  output logic [1:0]                    pending
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  typedef logic [N-1:0][N-1:0][W_OUT-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t        state_q, state_d;
  mat_t          bank_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [IW-1:0] row_q, col_q;
  logic [1:0]    pending_d;

  logic          capture_c, final_c, load_c, drop_c, ld_bank_c;
  logic [IW-1:0] ld_row_c, ld_col_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((pending != 2'd0) || valid_in) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM:  if (drop_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Selects which stored element (if any) enters the output register this edge.
  always_comb begin
    final_c   = 1'b0;
    load_c    = 1'b0;
    drop_c    = 1'b0;
    ld_bank_c = rd_ptr_q;
    ld_row_c  = '0;
    ld_col_c  = '0;
    case (state_q)
      LOAD: load_c = 1'b1;
      STREAM: begin
        if (!m_valid || m_ready) begin
          if (m_valid && m_last) begin
            final_c = 1'b1;
            // Other bank already full: start it on the same edge, no bubble.
            if (pending == 2'd2) begin
              load_c    = 1'b1;
              ld_bank_c = ~rd_ptr_q;
            end else begin
              drop_c = 1'b1;
            end
          end else begin
            load_c = 1'b1;
            if (!m_valid) begin
              ld_row_c = row_q;
              ld_col_c = col_q;
            end else if (col_q == IDX_MAX) begin
              ld_row_c = row_q + 1'b1;
            end else begin
              ld_row_c = row_q;
              ld_col_c = col_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    capture_c = valid_in && ((pending != 2'd2) || final_c);
    pending_d = pending + 2'(capture_c) - 2'(final_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      pending  <= 2'd0;
      full     <= 1'b0;
      overflow <= 1'b0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      overflow <= valid_in && !capture_c;
      pending  <= pending_d;
      full     <= (pending_d == 2'd2);
      if (capture_c) wr_ptr_q <= ~wr_ptr_q;
      if (final_c)   rd_ptr_q <= ~rd_ptr_q;
      if (load_c) begin
        m_data  <= bank_q[ld_bank_c][ld_row_c][ld_col_c];
        m_valid <= 1'b1;
        m_last  <= (ld_row_c == IDX_MAX) && (ld_col_c == IDX_MAX);
        row_q   <= ld_row_c;
        col_q   <= ld_col_c;
      end else if (drop_c) begin
        m_data  <= '0;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        row_q   <= '0;
        col_q   <= '0;
      end
    end
  end

  // Bank storage carries no reset; pending alone decides what is valid.
  always_ff @(posedge clk) begin
    if (capture_c) bank_q[wr_ptr_q] <= result_in;
  end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Bench for mat_result_serializer: directed scenarios plus a random run,
// with a matrix-level FIFO model of captures, drops and the expected beat stream.
module tb_mat_result_serializer;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned NN = N * N;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic        m_ready = 1'b0;
  mat_t        result_in = '0;
  logic signed [W-1:0] m_data;
  logic        m_valid, m_last, full, overflow;
  logic [1:0]  pending;

  int          n_vec = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q [$];
  int          beat_idx = 0;
  int          mp = 0;

  always #5 clk = ~clk;

  mat_result_serializer #(.W_OUT(W), .N(N)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .result_in(result_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .full(full), .overflow(overflow), .pending(pending)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t seq_mat(input int base);
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = W'(base + i * N + j);
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = W'($urandom);
    return m;
  endfunction

  // One clock: check the visible beat, update the model, then check status after the edge.
  task automatic step();
    bit fin, cap, ov;
    fin = 1'b0;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        chk("data", m_data, exp_q[0]);
        chk("last", W'(m_last), W'(beat_idx == NN - 1));
        if (m_ready) begin
          void'(exp_q.pop_front());
          if (beat_idx == NN - 1) begin
            fin = 1'b1;
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
      end
    end
    cap = valid_in && ((mp < 2) || fin);
    ov  = valid_in && !cap;
    mp  = mp + int'(cap) - int'(fin);
    if (cap)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          exp_q.push_back(result_in[i][j]);
    @(posedge clk);
    #1;
    chk("pending", W'(pending), W'(mp));
    chk("full", W'(full), W'(mp == 2));
    chk("overflow", W'(overflow), W'(ov));
  endtask

  task automatic drain(input int mode, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (c % 3 == 0);
        default: m_ready = ($urandom % 4) != 0;
      endcase
      step();
    end
    chk("drained", W'(exp_q.size()), 0);
  endtask

  task automatic send(input mat_t m);
    valid_in  = 1'b1;
    result_in = m;
    step();
    valid_in  = 1'b0;
  endtask

  initial begin
    int gaps, peak, guard;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", W'(m_valid), 0);
    chk("rst_m_last", W'(m_last), 0);
    chk("rst_full", W'(full), 0);
    chk("rst_overflow", W'(overflow), 0);
    chk("rst_pending", W'(pending), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single matrix, ready held high; m_valid rises 2 edges after valid_in.
    m_ready = 1'b1;
    send(seq_mat(0));
    chk("lat_edge_k", W'(m_valid), 0);
    step();
    chk("lat_edge_k1", W'(m_valid), 1);
    chk("first_elem", m_data, 0);
    drain(0, 200);
    chk("valid_after_last", W'(m_valid), 0);
    repeat (3) step();

    // Two matrices back to back, 5 cycles apart: 128 beats with no bubble.
    send(seq_mat(0));
    step();
    gaps = 0;
    peak = 0;
    for (int t = 0; t < 2 * NN; t++) begin
      valid_in  = (t == 3);
      result_in = seq_mat(1000);
      if (!m_valid) gaps++;
      step();
      if (int'(pending) > peak) peak = int'(pending);
    end
    valid_in = 1'b0;
    chk("gaps", W'(gaps), 0);
    chk("peak_pending", W'(peak), 2);
    chk("t2_drained", W'(exp_q.size()), 0);
    repeat (3) step();

    // Ready toggling 1,0,0: every element exactly once, held while stalled.
    m_ready = 1'b0;
    send(seq_mat(0));
    drain(1, 600);
    repeat (3) step();

    // Ready low, three pulses: third one dropped with a one-cycle overflow.
    m_ready = 1'b0;
    send(seq_mat(0));
    step();
    send(seq_mat(100));
    step();
    send(seq_mat(200));
    chk("t4_overflow", W'(overflow), 1);
    chk("t4_full", W'(full), 1);
    step();
    chk("t4_overflow_gone", W'(overflow), 0);
    drain(0, 400);
    repeat (3) step();

    // Full, third matrix arrives on the final beat of the first: accepted.
    m_ready = 1'b0;
    send(seq_mat(0));
    send(seq_mat(300));
    step();
    m_ready = 1'b1;
    guard = 0;
    while (!(m_valid && beat_idx == NN - 1) && guard < 200) begin
      step();
      guard++;
    end
    chk("t5_reached_last", W'(guard < 200), 1);
    send(seq_mat(600));
    chk("t5_overflow", W'(overflow), 0);
    chk("t5_pending", W'(pending), 2);
    drain(0, 400);
    repeat (3) step();

    // Reset mid-stream, then a fresh matrix streams from [0][0].
    m_ready = 1'b1;
    send(seq_mat(0));
    guard = 0;
    while (beat_idx != 20 && guard < 100) begin
      step();
      guard++;
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_valid", W'(m_valid), 0);
    chk("mid_rst_m_last", W'(m_last), 0);
    chk("mid_rst_pending", W'(pending), 0);
    chk("mid_rst_full", W'(full), 0);
    exp_q.delete();
    beat_idx = 0;
    mp = 0;
    @(negedge clk);
    rstn = 1'b1;
    send(seq_mat(500));
    drain(0, 200);

    // Large negative values pass through unchanged.
    send(seq_mat(-130048));
    drain(2, 600);
    repeat (3) step();

    // Random traffic with random back-pressure.
    for (int c = 0; c < 1500; c++) begin
      valid_in  = ($urandom % 40) == 0;
      result_in = rand_mat();
      m_ready   = ($urandom % 4) != 0;
      step();
    end
    valid_in = 1'b0;
    drain(2, 5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
